// File: rtl/cdb_arbiter_q_pkg.sv
// cdb_arbiter_q_pkg
// Shared types and defaults for the buffered completion-bus arbiter.
//   CDB_ENTRY           - {valid, tag, data} as broadcast on a CDB port
//   CDB_EARLY_TAG_ENTRY - {valid, tag} as seen by early wakeup
//   CDB_*_DEF           - default port/source counts and widths
//   cdb_ptr_w()         - FIFO pointer width, kept >= 1 so DEPTH=1 still builds
package cdb_arbiter_q_pkg;

    localparam int CDB_NUM_PORTS_DEF = 3;
    localparam int CDB_NUM_SRC_DEF   = 6;
    localparam int CDB_TAG_W_DEF     = 6;
    localparam int CDB_DATA_W_DEF    = 32;

    // Consumer-facing views at the default widths.
    typedef struct packed {
        logic                      valid;
        logic [CDB_TAG_W_DEF-1:0]  tag;
        logic [CDB_DATA_W_DEF-1:0] data;
    } CDB_ENTRY;

    typedef struct packed {
        logic                     valid;
        logic [CDB_TAG_W_DEF-1:0] tag;
    } CDB_EARLY_TAG_ENTRY;

    function automatic int cdb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo
// Per-source holding FIFO: one push, one pop per cycle, count exposed.
//   clock, clear   - clock; synchronous clear of pointers and count
//   push/push_data - write to tail (caller guarantees not full)
//   pop            - advance head (caller guarantees not empty)
//   head           - current head entry
//   count          - number of entries held
module cdb_src_fifo
    import cdb_arbiter_q_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = cdb_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    // Wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; pointers/count define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter_q.sv
// cdb_arbiter_q
// Buffered multi-port completion-bus arbiter. Each source pushes into its own
// FIFO; each cycle up to NUM_PORTS FIFO heads are picked in priority order,
// shown combinationally on early_*, and registered onto cdb_*.
//   clock, reset   - clock; synchronous active-high reset
//   flush          - squash all buffered and in-flight results
//   src_valid/tag/data, src_ready - per-source push interface
//   early_valid/tag - selected tags this cycle (wakeup one cycle early)
//   cdb_valid/tag/data - registered broadcast ports, compacted from port 0
//   occupancy_dbg  - per-source FIFO count
// Optional feature macro: CDB_AGE_PROMOTE_EN (age promotion of starved sources).
module cdb_arbiter_q
    import cdb_arbiter_q_pkg::*;
#(
    parameter int NUM_PORTS    = CDB_NUM_PORTS_DEF,
    parameter int NUM_SRC      = CDB_NUM_SRC_DEF,
    parameter int DEPTH        = 2,
    parameter int TAG_W        = CDB_TAG_W_DEF,
    parameter int DATA_W       = CDB_DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic [NUM_SRC-1:0]                        src_valid,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]             src_tag,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]            src_data,
    output logic [NUM_SRC-1:0]                        src_ready,
    output logic [NUM_PORTS-1:0]                      early_valid,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]           early_tag,
    output logic [NUM_PORTS-1:0]                      cdb_valid,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]           cdb_tag,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]          cdb_data,
    output logic [NUM_SRC-1:0][$clog2(DEPTH+1)-1:0]   occupancy_dbg
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } payload_t;

    logic                              clear;
    logic [NUM_SRC-1:0]                push, elig, promo, grant;
    logic [NUM_SRC-1:0][CNT_W-1:0]     count;
    payload_t [NUM_SRC-1:0]            head;
    logic [NUM_PORTS-1:0]              port_v;
    logic [NUM_PORTS-1:0][SRC_W-1:0]   port_src;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  port_data;

    assign clear = reset | flush;

    // Ready comes from the registered count only: a full FIFO refuses a push
    // even if it pops this cycle, which keeps src_ready off the grant path.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_ready[i] = (count[i] < CNT_W'(DEPTH));
        assign push[i]      = src_valid[i] & src_ready[i];
        assign elig[i]      = (count[i] != '0);

        cdb_src_fifo #(.DEPTH(DEPTH), .W($bits(payload_t))) u_fifo (
            .clock     (clock),
            .clear     (clear),
            .push      (push[i]),
            .push_data ({src_tag[i], src_data[i]}),
            .pop       (grant[i]),
            .head      (head[i]),
            .count     (count[i])
        );
    end

    assign occupancy_dbg = count;

`ifdef CDB_AGE_PROMOTE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT+1);
    logic [NUM_SRC-1:0][WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (clear || grant[i])
                wait_cnt[i] <= '0;
            else if (elig[i] && wait_cnt[i] != WAIT_W'(STARVE_LIMIT))
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            promo[i] = elig[i] && (wait_cnt[i] == WAIT_W'(STARVE_LIMIT));
    end
`else
    assign promo = '0;
`endif

    // First-N pick: each port in turn takes the lowest-index remaining
    // promoted request, else the lowest-index remaining normal request.
    always_comb begin
        logic [NUM_SRC-1:0] req_p, req_n;
        logic               found;
        req_p    = promo;
        req_n    = elig & ~promo;
        port_v   = '0;
        port_src = '0;
        grant    = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && req_p[i]) begin
                    found = 1'b1; req_p[i] = 1'b0; grant[i] = 1'b1;
                    port_v[k] = 1'b1; port_src[k] = SRC_W'(i);
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && req_n[i]) begin
                    found = 1'b1; req_n[i] = 1'b0; grant[i] = 1'b1;
                    port_v[k] = 1'b1; port_src[k] = SRC_W'(i);
                end
            end
        end
        // Nothing leaves during flush/reset; the FIFOs are emptied anyway.
        if (clear) begin
            port_v = '0;
            grant  = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            early_valid[k] = port_v[k];
            early_tag[k]   = port_v[k] ? head[port_src[k]].tag  : '0;
            port_data[k]   = port_v[k] ? head[port_src[k]].data : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= port_v;
            cdb_tag   <= early_tag;
            cdb_data  <= port_data;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter_q.sv
module tb_cdb_arbiter_q;

    localparam int NP = 3, NS = 6, DEPTH = 2, TW = 6, DW = 32, SL = 4;
    localparam int CW = $clog2(DEPTH+1);
`ifdef CDB_AGE_PROMOTE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     reset, flush;
    logic [NS-1:0]            src_valid;
    logic [NS-1:0][TW-1:0]    src_tag;
    logic [NS-1:0][DW-1:0]    src_data;
    logic [NS-1:0]            src_ready;
    logic [NP-1:0]            early_valid;
    logic [NP-1:0][TW-1:0]    early_tag;
    logic [NP-1:0]            cdb_valid;
    logic [NP-1:0][TW-1:0]    cdb_tag;
    logic [NP-1:0][DW-1:0]    cdb_data;
    logic [NS-1:0][CW-1:0]    occupancy_dbg;

    cdb_arbiter_q #(.NUM_PORTS(NP), .NUM_SRC(NS), .DEPTH(DEPTH), .TAG_W(TW),
                    .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready), .early_valid(early_valid), .early_tag(early_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .occupancy_dbg(occupancy_dbg));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_cond(input string name, input bit ok, input logic [63:0] act);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: value %0h violates the rule (t=%0t)", name, act, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queues of pending results per source; a result pushed at an edge is
    // visible the next cycle. Each cycle the first NP nonempty sources (aged
    // ones first when promotion is built in) are broadcast and popped.
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; } ent_t;
    ent_t                   q [NS][$];
    int                     m_wait [NS];
    logic [NP-1:0]          m_cv;
    logic [NP-1:0][TW-1:0]  m_ct;
    logic [NP-1:0][DW-1:0]  m_cd;
    bit                     live = 1'b0;

    always @(negedge clock) begin
        int            sel[$];
        int            pre[NS];
        bit            gr[NS];
        logic [NS-1:0] exp_rdy;
        ent_t          e;
        sel.delete();
        for (int i = 0; i < NS; i++) begin
            pre[i] = q[i].size();
            gr[i]  = 1'b0;
        end
        if (!(reset || flush))
            for (int pass = 0; pass < 2; pass++)
                for (int i = 0; i < NS; i++)
                    if (pre[i] > 0 && !gr[i] && ((AGE && m_wait[i] >= SL) == (pass == 0))
                        && sel.size() < NP) begin
                        sel.push_back(i);
                        gr[i] = 1'b1;
                    end

        if (live) begin
            for (int i = 0; i < NS; i++) exp_rdy[i] = (pre[i] < DEPTH);
            chk("model src_ready", src_ready, exp_rdy);
            for (int i = 0; i < NS; i++) chk("model occupancy", occupancy_dbg[i], pre[i]);
            chk("model early_valid", early_valid, (64'd1 << sel.size()) - 64'd1);
            for (int k = 0; k < sel.size(); k++)
                chk("model early_tag", early_tag[k], q[sel[k]][0].tag);
            chk("model cdb_valid", cdb_valid, m_cv);
            for (int k = 0; k < NP; k++)
                if (m_cv[k]) begin
                    chk("model cdb_tag", cdb_tag[k], m_ct[k]);
                    chk("model cdb_data", cdb_data[k], m_cd[k]);
                end
        end

        if (reset || flush) begin
            for (int i = 0; i < NS; i++) begin
                q[i].delete();
                m_wait[i] = 0;
            end
            m_cv = '0; m_ct = '0; m_cd = '0;
            live = 1'b1;
        end else begin
            m_cv = '0; m_ct = '0; m_cd = '0;
            for (int k = 0; k < sel.size(); k++) begin
                e = q[sel[k]].pop_front();
                m_cv[k] = 1'b1; m_ct[k] = e.tag; m_cd[k] = e.data;
            end
            for (int i = 0; i < NS; i++) begin
                if (gr[i]) m_wait[i] = 0;
                else if (pre[i] > 0 && m_wait[i] < SL) m_wait[i]++;
                if (src_valid[i] && pre[i] < DEPTH) begin
                    e.tag = src_tag[i]; e.data = src_data[i];
                    q[i].push_back(e);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        src_valid[i] = 1'b1;
        src_tag[i]   = t;
        src_data[i]  = d;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
        step(); step();
        // reset state
        @(negedge clock);
        chk("reset cdb_valid", cdb_valid, 0);
        chk("reset cdb_tag", cdb_tag, 0);
        chk("reset cdb_data", cdb_data, 0);
        chk("reset src_ready", src_ready, 6'h3f);
        chk("reset occupancy", occupancy_dbg, 0);
        chk("reset early_valid", early_valid, 0);
        step();
        reset = 1'b0;

        // single push, 2-cycle latency
        drive(2, 6'h15, 32'hDEAD);
        step();
        src_valid = '0;
        @(negedge clock);
        chk("single early_valid", early_valid, 3'b001);
        chk("single early_tag0", early_tag[0], 6'h15);
        step();
        @(negedge clock);
        chk("single cdb_valid", cdb_valid, 3'b001);
        chk("single cdb_tag0", cdb_tag[0], 6'h15);
        chk("single cdb_data0", cdb_data[0], 32'hDEAD);
        step();

        // all six push at once
        for (int i = 0; i < NS; i++) drive(i, TW'(6'h20 + i), DW'(32'h111 * i));
        step();
        src_valid = '0;
        @(negedge clock);
        chk("all6 early_valid", early_valid, 3'b111);
        for (int k = 0; k < NP; k++) chk("all6 early_tag first", early_tag[k], 64'h20 + k);
        chk("all6 src_ready", src_ready, 6'h3f);
        step();
        @(negedge clock);
        for (int k = 0; k < NP; k++) chk("all6 cdb_tag first", cdb_tag[k], 64'h20 + k);
        for (int k = 0; k < NP; k++) chk("all6 early_tag second", early_tag[k], 64'h23 + k);
        step();
        @(negedge clock);
        chk("all6 cdb_valid second", cdb_valid, 3'b111);
        for (int k = 0; k < NP; k++) chk("all6 cdb_tag second", cdb_tag[k], 64'h23 + k);
        for (int k = 0; k < NP; k++) chk("all6 cdb_data second", cdb_data[k], 64'h111 * (3 + k));
        step();

        // source 5 fills its FIFO while 0-2 saturate the ports
        for (int c = 0; c < 3; c++) begin
            src_valid = '0;
            for (int i = 0; i < 3; i++) drive(i, TW'(8 * i + c), DW'(c));
            drive(5, TW'(6'h38 + c), DW'(32'h5000 + c));
            if (c == 2) begin
                @(negedge clock);
                chk("fill src_ready5", src_ready[5], 1'b0);
                chk("fill occupancy5", occupancy_dbg[5], 2);
            end
            step();
        end
        src_valid = '0;
        @(negedge clock);
        chk("fill third push rejected", occupancy_dbg[5], 2);
        step();
        repeat (4) step();

        // starvation of source 5
        for (int c = 0; c < 10; c++) begin
            src_valid = '0;
            for (int i = 0; i < 3; i++) drive(i, TW'(8 * i + (c & 7)), DW'(32'h100 + c));
            if (c == 0) drive(5, 6'h35, 32'h5555);
            if (c >= 1) begin
                @(negedge clock);
                if (AGE && c == 5) begin
                    chk("age grant valid0", early_valid[0], 1'b1);
                    chk("age grant tag0", early_tag[0], 6'h35);
                end else begin
                    for (int k = 0; k < NP; k++)
                        chk_cond("starve src5 not granted",
                                 !(early_valid[k] && early_tag[k] == 6'h35), early_tag[k]);
                end
            end
            step();
        end
        src_valid = '0;
        repeat (6) step();

        // flush mid-stream with sources 3-5 full
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NS; i++) drive(i, TW'(8 * i + c), DW'(32'h200 + c));
            step();
        end
        flush = 1'b1;
        for (int i = 0; i < NS; i++) drive(i, 6'h3f, 32'hFFFF);
        @(negedge clock);
        chk("preflush cdb_valid", cdb_valid, 3'b111);
        chk("preflush occupancy5", occupancy_dbg[5], 2);
        chk("flush early_valid", early_valid, 0);
        step();
        flush = 1'b0;
        src_valid = '0;
        @(negedge clock);
        chk("postflush cdb_valid", cdb_valid, 0);
        chk("postflush occupancy", occupancy_dbg, 0);
        chk("postflush src_ready", src_ready, 6'h3f);
        chk("postflush push dropped", early_valid, 0);
        step();

        // full FIFO: pop with rejected push, order kept across wrap
        for (int i = 0; i < 3; i++) drive(i, TW'(8 * i), 32'h300);
        drive(3, 6'h3a, 32'hA);
        step();
        src_valid = '0;
        for (int i = 0; i < 3; i++) drive(i, TW'(8 * i + 1), 32'h301);
        drive(3, 6'h3b, 32'hB);
        step();
        src_valid = '0;
        @(negedge clock);
        chk("wrap full ready3", src_ready[3], 1'b0);
        chk("wrap full occupancy3", occupancy_dbg[3], 2);
        step();
        drive(3, 6'h3c, 32'hC);
        @(negedge clock);
        chk("wrap pop early_valid", early_valid, 3'b001);
        chk("wrap pop early_tag", early_tag[0], 6'h3a);
        chk("wrap pop ready3", src_ready[3], 1'b0);
        step();
        src_valid = '0;
        drive(3, 6'h3d, 32'hD);
        @(negedge clock);
        chk("wrap occ after pop", occupancy_dbg[3], 1);
        chk("wrap cdb A", cdb_tag[0], 6'h3a);
        chk("wrap early B", early_tag[0], 6'h3b);
        step();
        src_valid = '0;
        @(negedge clock);
        chk("wrap occ push+pop", occupancy_dbg[3], 1);
        chk("wrap cdb B", cdb_tag[0], 6'h3b);
        chk("wrap early D", early_tag[0], 6'h3d);
        step();
        @(negedge clock);
        chk("wrap cdb D valid", cdb_valid, 3'b001);
        chk("wrap cdb D", cdb_tag[0], 6'h3d);
        chk("wrap cdb D data", cdb_data[0], 32'hD);
        chk("wrap occ empty", occupancy_dbg[3], 0);
        step();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
